// File: rtl/pic_in_service_unit.sv
// pic_in_service_unit: priority resolution, two-pulse INTA handshake and in-service register.
// Applies specific, non-specific and automatic EOI with optional rotation of the lowest priority.
module pic_in_service_unit #(
  parameter int NUM_IRQ = 8,
  localparam int ID_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               inta_first,
  input  logic               inta_second,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               eoi_rotate,
  input  logic               aeoi_mode,
  input  logic               rotate_on_aeoi,
  output logic               int_out,
  output logic [ID_W-1:0]    vector_id,
  output logic [NUM_IRQ-1:0] clear_irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    lowest_prio
);

  // state | meaning
  // IDLE  | nothing presented to the CPU
  // REQ   | int_out high, waiting for inta_first
  // WAIT2 | vector frozen, waiting for inta_second
  typedef enum logic [1:0] {IDLE, REQ, WAIT2} state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] id;
  } pick_t;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction

  // Rotate the vector so the highest-priority channel lands at bit 0, then take the lowest set bit.
  function automatic pick_t pick_top(input logic [NUM_IRQ-1:0] vec, input logic [ID_W-1:0] lp);
    logic [ID_W-1:0]      start;
    logic [2*NUM_IRQ-1:0] dbl;
    int                   pos;
    pick_t                r;
    r     = '0;
    start = (lp == ID_W'(NUM_IRQ - 1)) ? '0 : lp + 1'b1;
    dbl   = {vec, vec} >> start;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        pos = int'(start) + k;
        if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
        r.found = 1'b1;
        r.id    = ID_W'(pos);
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d, clear_irr_q, clear_irr_d, isr_eoi;
  logic [ID_W-1:0]    lowest_prio_q, lowest_prio_d, vector_id_q, vector_id_d, lp_eoi;
  logic               int_out_q, int_out_d, spurious_q, spurious_d, eoi_rot, qualify;
  pick_t              isr_top, best;

  always_comb begin
    state_d       = state_q;
    int_out_d     = int_out_q;
    vector_id_d   = vector_id_q;
    spurious_d    = spurious_q;
    clear_irr_d   = '0;
    isr_eoi       = isr_q;
    lp_eoi        = lowest_prio_q;
    eoi_rot       = 1'b0;
    isr_top       = pick_top(isr_q, lowest_prio_q);

    if (eoi_valid) begin
      if (eoi_specific) begin
        if (32'(eoi_id) < NUM_IRQ) begin
          isr_eoi = isr_q & ~onehot(eoi_id);
          if (eoi_rotate) begin
            lp_eoi  = eoi_id;
            eoi_rot = 1'b1;
          end
        end
      end else if (isr_top.found) begin
        isr_eoi = isr_q & ~onehot(isr_top.id);
        if (eoi_rotate) begin
          lp_eoi  = isr_top.id;
          eoi_rot = 1'b1;
        end
      end
    end

    // The top of (candidates | ISR) qualifies only if it is a candidate strictly above every ISR bit.
    best          = pick_top((irr & ~imr) | isr_eoi, lp_eoi);
    qualify       = best.found && ((isr_eoi & onehot(best.id)) == '0);
    isr_d         = isr_eoi;
    lowest_prio_d = lp_eoi;

    case (state_q)
      IDLE, REQ: begin
        if (inta_first) begin
          state_d   = WAIT2;
          int_out_d = 1'b0;
          if (qualify) begin
            isr_d       = isr_eoi | onehot(best.id);
            vector_id_d = best.id;
            clear_irr_d = onehot(best.id);
            spurious_d  = 1'b0;
          end else begin
            vector_id_d = ID_W'(NUM_IRQ - 1);
            spurious_d  = 1'b1;
          end
        end else begin
          state_d   = qualify ? REQ : IDLE;
          int_out_d = qualify;
        end
      end
      WAIT2: begin
        int_out_d = 1'b0;
        if (inta_second) begin
          state_d = IDLE;
          if (aeoi_mode && !spurious_q) begin
            isr_d = isr_d & ~onehot(vector_id_q);
            if (rotate_on_aeoi && !eoi_rot) lowest_prio_d = vector_id_q;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        int_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      isr_q         <= '0;
      int_out_q     <= 1'b0;
      vector_id_q   <= '0;
      clear_irr_q   <= '0;
      lowest_prio_q <= ID_W'(NUM_IRQ - 1);
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      isr_q         <= isr_d;
      int_out_q     <= int_out_d;
      vector_id_q   <= vector_id_d;
      clear_irr_q   <= clear_irr_d;
      lowest_prio_q <= lowest_prio_d;
      spurious_q    <= spurious_d;
    end
  end

  assign int_out     = int_out_q;
  assign vector_id   = vector_id_q;
  assign clear_irr   = clear_irr_q;
  assign isr         = isr_q;
  assign lowest_prio = lowest_prio_q;

endmodule
